// File: rtl/fetch_pc_unit.sv
// Fetch program-counter unit: sequences fetch requests to instruction memory,
// follows the branch predictor, and takes execute-stage redirects with priority.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] PredNextPC,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        FetchReady,
  output logic [31:0] PC,
  output logic        FetchValid,
  output logic        Flush,
  output logic [15:0] MispredCount,
  output logic        MisalignErr,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    STALL  = 2'd2,
    BUBBLE = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] next_pc;
  logic        handshake;

  // Handshake: a request at PC is accepted on a rising edge where FetchValid
  // and FetchReady are both 1. Once raised, FetchValid stays up until accepted;
  // only a Redirect may withdraw it.
  assign handshake = FetchValid & FetchReady;
  assign dbg_state = state;

  always_comb begin
    next_state = state;
    next_pc    = PC;
    if (Redirect) begin
      next_state = BUBBLE;
      next_pc    = {RedirectPC[31:2], 2'b00};
    end else begin
      case (state)
        BOOT:   next_state = FETCH;
        FETCH: begin
          if (handshake) begin
            next_pc    = PredNextPC;
            next_state = Stall ? STALL : FETCH;
          end
        end
        STALL:  if (!Stall) next_state = FETCH;
        BUBBLE: next_state = Stall ? STALL : FETCH;
        default: next_state = BOOT;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= BOOT;
      PC           <= RESET_VECTOR;
      FetchValid   <= 1'b0;
      Flush        <= 1'b0;
      MispredCount <= 16'h0000;
      MisalignErr  <= 1'b0;
    end else begin
      state      <= next_state;
      PC         <= next_pc;
      FetchValid <= (next_state == FETCH);
      Flush      <= Redirect;
      if (Redirect && (MispredCount != 16'hFFFF))
        MispredCount <= MispredCount + 16'h0001;
      if (Redirect && (RedirectPC[1:0] != 2'b00))
        MisalignErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model of the fetch rules.
module tb_fetch_pc_unit;

  logic        Clk;
  logic        Rst_n;
  logic [31:0] PredNextPC;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        FetchReady;
  logic [31:0] PC;
  logic        FetchValid;
  logic        Flush;
  logic [15:0] MispredCount;
  logic        MisalignErr;
  logic [1:0]  dbg_state;

  fetch_pc_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .PredNextPC(PredNextPC), .Stall(Stall),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .FetchReady(FetchReady),
    .PC(PC), .FetchValid(FetchValid), .Flush(Flush),
    .MispredCount(MispredCount), .MisalignErr(MisalignErr), .dbg_state(dbg_state)
  );

  // clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // behavioural model: what the fetch unit must be showing right now
  logic [31:0] m_pc;
  bit          m_valid;    // request outstanding
  bit          m_boot;     // first cycle after reset
  bit          m_parked;   // held off by hazard unit
  bit          m_flush;
  int          m_cnt;
  bit          m_err;
  logic [31:0] exp_q[$];   // addresses the memory must see accepted, in order

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 0; m_boot = 1; m_parked = 0;
    m_flush = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic model_step(input bit st, input bit rdr, input logic [31:0] rpc,
                            input bit rdy, input logic [31:0] pred);
    m_flush = rdr;
    if (rdr) begin
      m_pc     = rpc & 32'hFFFF_FFFC;
      m_cnt    = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
      m_err    = m_err | (rpc[1:0] != 2'b00);
      m_valid  = 0; m_parked = 0; m_boot = 0;
    end else if (m_boot) begin
      m_boot = 0; m_valid = 1;
    end else if (m_valid) begin
      if (rdy) begin
        m_pc = pred;
        if (st) begin m_valid = 0; m_parked = 1; end
      end
    end else if (m_parked) begin
      if (!st) begin m_parked = 0; m_valid = 1; end
    end else begin
      if (st) m_parked = 1; else m_valid = 1;
    end
  endtask

  task automatic check_all();
    chk("pc", PC, m_pc);
    chk("fetch_valid", {31'b0, FetchValid}, {31'b0, m_valid});
    chk("flush", {31'b0, Flush}, {31'b0, m_flush});
    chk("mispred_count", {16'b0, MispredCount}, m_cnt[31:0]);
    chk("misalign_err", {31'b0, MisalignErr}, {31'b0, m_err});
  endtask

  // driver: called just after a falling edge; returns just after the next one
  task automatic step(input bit st, input bit rdr, input logic [31:0] rpc,
                      input bit rdy, input bit rand_pred);
    logic [31:0] pred;
    pred       = rand_pred ? $urandom() : PC + 32'd4;
    Stall      = st;
    Redirect   = rdr;
    RedirectPC = rpc;
    FetchReady = rdy;
    PredNextPC = pred;
    if (m_valid && rdy && !rdr) exp_q.push_back(m_pc);
    if (FetchValid && rdy && !rdr) begin
      if (exp_q.size() == 0) chk("accept_unexpected", PC, 32'hXXXX_XXXX);
      else chk("accepted_addr", PC, exp_q.pop_front());
    end
    @(posedge Clk);
    model_step(st, rdr, rpc, rdy, pred);
    #1 check_all();
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    Stall = 0; Redirect = 0; RedirectPC = 0; FetchReady = 0; PredNextPC = 0;
  endtask

  // asynchronous reset applied between edges; outputs must clear before the next edge
  task automatic do_reset();
    Rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("pending_accepts_at_reset", exp_q.size(), 32'd0);
    exp_q.delete();
    model_reset();
    check_all();
    chk("reset_pc_literal", PC, 32'h0000_0000);
    chk("reset_valid_literal", {31'b0, FetchValid}, 32'd0);
    chk("reset_err_literal", {31'b0, MisalignErr}, 32'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1 check_all();
  endtask

  initial begin
    Rst_n = 1'b0;
    idle_inputs();
    @(negedge Clk);
    do_reset();

    // boot, then sequential fetch 0,4,8
    chk("boot_valid_low", {31'b0, FetchValid}, 32'd0);
    step(0, 0, 0, 1, 0);
    chk("first_valid", {31'b0, FetchValid}, 32'd1);
    chk("seq_pc0", PC, 32'h0);
    step(0, 0, 0, 1, 0);
    chk("seq_pc4", PC, 32'h4);
    step(0, 0, 0, 1, 0);
    chk("seq_pc8", PC, 32'h8);

    // memory not ready for 3 cycles with a stall pulse: request must hold
    for (int i = 0; i < 3; i++) begin
      step(i == 1, 0, 0, 0, 0);
      chk("hold_pc8", PC, 32'h8);
      chk("hold_valid", {31'b0, FetchValid}, 32'd1);
    end
    step(1, 0, 0, 1, 0);
    chk("stall_pc12", PC, 32'hC);
    chk("stall_valid_low", {31'b0, FetchValid}, 32'd0);
    step(1, 0, 0, 1, 0);
    chk("stall_still_low", {31'b0, FetchValid}, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("stall_release", {31'b0, FetchValid}, 32'd1);

    // redirect coincident with a handshake
    step(0, 1, 32'h0000_0100, 1, 0);
    chk("redir_pc", PC, 32'h100);
    chk("redir_flush", {31'b0, Flush}, 32'd1);
    chk("redir_valid_low", {31'b0, FetchValid}, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("redir_refetch", {31'b0, FetchValid}, 32'd1);
    chk("redir_flush_gone", {31'b0, Flush}, 32'd0);
    chk("redir_count", {16'b0, MispredCount}, 32'd1);

    // misaligned redirect target, sticky error
    step(0, 1, 32'h0000_0206, 0, 0);
    chk("misalign_pc", PC, 32'h204);
    chk("misalign_set", {31'b0, MisalignErr}, 32'd1);
    repeat (3) step(0, 0, 0, 1, 0);
    chk("misalign_sticky", {31'b0, MisalignErr}, 32'd1);

    // redirect during bubble, then PC wrap at top of address space
    step(0, 1, 32'h0000_0040, 0, 0);
    step(0, 1, 32'hFFFF_FFFC, 0, 0);
    chk("bubble_reflush", {31'b0, Flush}, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("wrap_top", PC, 32'hFFFF_FFFC);
    step(0, 0, 0, 1, 0);
    chk("wrap_zero", PC, 32'h0);

    // park in STALL, then reset between edges
    step(1, 0, 0, 1, 0);
    chk("park_valid_low", {31'b0, FetchValid}, 32'd0);
    do_reset();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
             $urandom(), $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
      end
    end

    // drive the redirect counter into saturation, then three more
    while (m_cnt < 65535) step(0, 1, $urandom() & 32'hFFFF_FFFC, 0, 0);
    chk("count_ffff", {16'b0, MispredCount}, 32'h0000_FFFF);
    repeat (3) step(0, 1, 32'h0000_0080, 1, 0);
    chk("count_saturated", {16'b0, MispredCount}, 32'h0000_FFFF);
    step(0, 0, 0, 0, 0);

    do_reset();
    chk("count_cleared", {16'b0, MispredCount}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
